// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: picks one of the ALU and load writeback requests
// per cycle, registers the winning write, and counts cycles where both collide.
module regfile_wb_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             AluValid,
  input  logic [4:0]       AluRW,
  input  logic [31:0]      AluData,
  output logic             AluReady,
  input  logic             MemValid,
  input  logic [4:0]       MemRW,
  input  logic [31:0]      MemData,
  output logic             MemReady,
  output logic             RegWr,
  output logic [4:0]       RW,
  output logic [31:0]      BusW,
  output logic [CNT_W-1:0] ConflictCnt
);

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e    last;
  logic    alu_pref;
  logic    xfer;
  logic    conflict;
  wb_req_t alu_req, mem_req, grant_req;

  assign alu_req  = '{rw: AluRW, data: AluData};
  assign mem_req  = '{rw: MemRW, data: MemData};
  assign conflict = AluValid & MemValid;

  // On a conflict ALU wins only in round-robin mode when MEM was the last grant.
  assign alu_pref = (PRIO_MODE == 0) && (last == SRC_MEM);

  assign AluReady  = Resetn & AluValid & (~MemValid | alu_pref);
  assign MemReady  = Resetn & MemValid & (~AluValid | ~alu_pref);
  assign xfer      = AluReady | MemReady;
  assign grant_req = AluReady ? alu_req : mem_req;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      RegWr       <= 1'b0;
      RW          <= '0;
      BusW        <= '0;
      ConflictCnt <= '0;
      last        <= SRC_MEM;
    end else begin
      // Writes to r0 are consumed like any other grant but never reach the file.
      RegWr <= xfer && (grant_req.rw != 5'd0);
      if (xfer) begin
        RW   <= grant_req.rw;
        BusW <= grant_req.data;
        last <= AluReady ? SRC_ALU : SRC_MEM;
      end
      if (conflict && (ConflictCnt != {CNT_W{1'b1}}))
        ConflictCnt <= ConflictCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: round-robin, fixed-priority and narrow-counter instances share stimulus.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        AluValid, MemValid;
  logic [4:0]  AluRW, MemRW;
  logic [31:0] AluData, MemData;

  logic        alu_rdy_rr, mem_rdy_rr, wr_rr;
  logic [4:0]  rw_rr;
  logic [31:0] bus_rr;
  logic [15:0] cnt_rr;

  logic        alu_rdy_fp, mem_rdy_fp, wr_fp;
  logic [4:0]  rw_fp;
  logic [31:0] bus_fp;
  logic [15:0] cnt_fp;

  logic        alu_rdy_sc, mem_rdy_sc, wr_sc;
  logic [4:0]  rw_sc;
  logic [31:0] bus_sc;
  logic [1:0]  cnt_sc;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.PRIO_MODE(0), .CNT_W(16)) dut_rr (
    .Clk(Clk), .Resetn(Resetn),
    .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(alu_rdy_rr),
    .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(mem_rdy_rr),
    .RegWr(wr_rr), .RW(rw_rr), .BusW(bus_rr), .ConflictCnt(cnt_rr));

  regfile_wb_arbiter #(.PRIO_MODE(1), .CNT_W(16)) dut_fp (
    .Clk(Clk), .Resetn(Resetn),
    .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(alu_rdy_fp),
    .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(mem_rdy_fp),
    .RegWr(wr_fp), .RW(rw_fp), .BusW(bus_fp), .ConflictCnt(cnt_fp));

  regfile_wb_arbiter #(.PRIO_MODE(0), .CNT_W(2)) dut_sc (
    .Clk(Clk), .Resetn(Resetn),
    .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(alu_rdy_sc),
    .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(mem_rdy_sc),
    .RegWr(wr_sc), .RW(rw_sc), .BusW(bus_sc), .ConflictCnt(cnt_sc));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    AluValid = 1'b0; MemValid = 1'b0;
    AluRW = 5'd0; MemRW = 5'd0; AluData = '0; MemData = '0;
  endtask

  task automatic do_reset();
    idle();
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    // Put something in the output registers first so reset has work to do.
    AluValid = 1'b1; AluRW = 5'd7; AluData = 32'hDEAD_0007;
    tick();
    AluRW = 5'd8; AluData = 32'h0000_0008;
    Resetn = 1'b0;
    #1;
    n_chk++;
    if (alu_rdy_rr !== 1'b0 || mem_rdy_rr !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got alu=%b mem=%b want 0 0", alu_rdy_rr, mem_rdy_rr);
    end
    tick();
    n_chk++;
    if (wr_rr !== 1'b0 || rw_rr !== 5'd0 || bus_rr !== 32'd0 || cnt_rr !== 16'd0) begin
      n_err++; $display("FAIL reset_outputs: got wr=%b rw=%0d bus=%h cnt=%0d want 0 0 0 0",
                        wr_rr, rw_rr, bus_rr, cnt_rr);
    end
    Resetn = 1'b1;
    idle();
    tick();
    n_chk++;
    if (wr_rr !== 1'b0) begin
      n_err++; $display("FAIL reset_discard: got wr=%b want 0", wr_rr);
    end
    AluValid = 1'b1; AluRW = 5'd1; AluData = 32'h0000_00A1;
    MemValid = 1'b1; MemRW = 5'd2; MemData = 32'h0000_00B2;
    #1;
    n_chk++;
    if (alu_rdy_rr !== 1'b1 || mem_rdy_rr !== 1'b0) begin
      n_err++; $display("FAIL reset_first_conflict: got alu=%b mem=%b want 1 0", alu_rdy_rr, mem_rdy_rr);
    end
    tick();
    n_chk++;
    if (rw_rr !== 5'd1 || bus_rr !== 32'h0000_00A1 || wr_rr !== 1'b1) begin
      n_err++; $display("FAIL reset_first_write: got wr=%b rw=%0d bus=%h want 1 1 000000a1",
                        wr_rr, rw_rr, bus_rr);
    end
    idle();
  endtask

  task automatic test_single_alu();
    do_reset();
    AluValid = 1'b1; AluRW = 5'd5; AluData = 32'h0000_1234;
    #1;
    n_chk++;
    if (alu_rdy_rr !== 1'b1 || mem_rdy_rr !== 1'b0) begin
      n_err++; $display("FAIL single_ready: got alu=%b mem=%b want 1 0", alu_rdy_rr, mem_rdy_rr);
    end
    tick();
    idle();
    n_chk++;
    if (wr_rr !== 1'b1 || rw_rr !== 5'd5 || bus_rr !== 32'h0000_1234) begin
      n_err++; $display("FAIL single_write: got wr=%b rw=%0d bus=%h want 1 5 00001234", wr_rr, rw_rr, bus_rr);
    end
    tick();
    n_chk++;
    if (wr_rr !== 1'b0 || rw_rr !== 5'd5 || bus_rr !== 32'h0000_1234) begin
      n_err++; $display("FAIL single_pulse_end: got wr=%b rw=%0d bus=%h want 0 5 00001234", wr_rr, rw_rr, bus_rr);
    end
  endtask

  task automatic test_back_to_back();
    int ak = 0;
    int mk = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic        exp_alu;
      logic [4:0]  exp_rw;
      logic [31:0] exp_bus;
      AluValid = 1'b1; AluRW = 5'd3; AluData = 32'hA000_0000 + 32'(ak);
      MemValid = 1'b1; MemRW = 5'd4; MemData = 32'hB000_0000 + 32'(mk);
      exp_alu = (i % 2 == 0);
      exp_rw  = exp_alu ? 5'd3 : 5'd4;
      exp_bus = exp_alu ? 32'hA000_0000 + 32'(ak) : 32'hB000_0000 + 32'(mk);
      #1;
      n_chk++;
      if (alu_rdy_rr !== exp_alu || mem_rdy_rr !== !exp_alu) begin
        n_err++; $display("FAIL rr_grant[%0d]: got alu=%b mem=%b want %b %b",
                          i, alu_rdy_rr, mem_rdy_rr, exp_alu, !exp_alu);
      end
      tick();
      n_chk++;
      if (wr_rr !== 1'b1 || rw_rr !== exp_rw || bus_rr !== exp_bus) begin
        n_err++; $display("FAIL rr_write[%0d]: got wr=%b rw=%0d bus=%h want 1 %0d %h",
                          i, wr_rr, rw_rr, bus_rr, exp_rw, exp_bus);
      end
      if (exp_alu) ak++; else mk++;
    end
    n_chk++;
    if (cnt_rr !== 16'd4) begin
      n_err++; $display("FAIL rr_conflict_cnt: got %0d want 4", cnt_rr);
    end
    idle();
    tick();
    n_chk++;
    if (wr_rr !== 1'b0) begin
      n_err++; $display("FAIL rr_idle: got wr=%b want 0", wr_rr);
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    AluValid = 1'b1; AluRW = 5'd6; AluData = 32'h0000_0111;
    MemValid = 1'b1; MemRW = 5'd6; MemData = 32'h0000_0222;
    tick();
    AluValid = 1'b0;
    n_chk++;
    if (rw_rr !== 5'd6 || bus_rr !== 32'h0000_0111) begin
      n_err++; $display("FAIL same_reg_first: got rw=%0d bus=%h want 6 00000111", rw_rr, bus_rr);
    end
    tick();
    idle();
    n_chk++;
    if (wr_rr !== 1'b1 || rw_rr !== 5'd6 || bus_rr !== 32'h0000_0222) begin
      n_err++; $display("FAIL same_reg_second: got wr=%b rw=%0d bus=%h want 1 6 00000222", wr_rr, rw_rr, bus_rr);
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    AluValid = 1'b1; AluRW = 5'd2; AluData = 32'h0000_AAAA;
    for (int i = 0; i < 3; i++) begin
      MemValid = 1'b1; MemRW = 5'(9 + i); MemData = 32'hC000_0000 + 32'(i);
      #1;
      n_chk++;
      if (mem_rdy_fp !== 1'b1 || alu_rdy_fp !== 1'b0) begin
        n_err++; $display("FAIL fp_grant[%0d]: got alu=%b mem=%b want 0 1", i, alu_rdy_fp, mem_rdy_fp);
      end
      tick();
      n_chk++;
      if (wr_fp !== 1'b1 || rw_fp !== 5'(9 + i) || bus_fp !== 32'hC000_0000 + 32'(i)) begin
        n_err++; $display("FAIL fp_write[%0d]: got wr=%b rw=%0d bus=%h want 1 %0d %h",
                          i, wr_fp, rw_fp, bus_fp, 9 + i, 32'hC000_0000 + 32'(i));
      end
    end
    idle();
  endtask

  task automatic test_reg_zero();
    do_reset();
    MemValid = 1'b1; MemRW = 5'd0; MemData = 32'hFFFF_FFFF;
    #1;
    n_chk++;
    if (mem_rdy_rr !== 1'b1) begin
      n_err++; $display("FAIL r0_ready: got mem=%b want 1", mem_rdy_rr);
    end
    tick();
    idle();
    n_chk++;
    if (wr_rr !== 1'b0) begin
      n_err++; $display("FAIL r0_no_write: got wr=%b want 0", wr_rr);
    end
    // An ALU r0 write must still move LAST to ALU, so the next conflict goes to MEM.
    AluValid = 1'b1; AluRW = 5'd0; AluData = 32'h0000_5555;
    tick();
    n_chk++;
    if (wr_rr !== 1'b0) begin
      n_err++; $display("FAIL r0_alu_no_write: got wr=%b want 0", wr_rr);
    end
    AluRW = 5'd12; AluData = 32'h0000_0C0C;
    MemValid = 1'b1; MemRW = 5'd13; MemData = 32'h0000_0D0D;
    #1;
    n_chk++;
    if (mem_rdy_rr !== 1'b1 || alu_rdy_rr !== 1'b0) begin
      n_err++; $display("FAIL r0_last_update: got alu=%b mem=%b want 0 1", alu_rdy_rr, mem_rdy_rr);
    end
    tick();
    idle();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    AluValid = 1'b1; AluRW = 5'd1; AluData = 32'h1;
    MemValid = 1'b1; MemRW = 5'd2; MemData = 32'h2;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (cnt_sc !== exp_cnt[i]) begin
        n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnt_sc, exp_cnt[i]);
      end
    end
    idle();
    tick();
    n_chk++;
    if (cnt_sc !== 2'd3 || cnt_rr !== 16'd5) begin
      n_err++; $display("FAIL sat_hold: got narrow=%0d wide=%0d want 3 5", cnt_sc, cnt_rr);
    end
  endtask

  initial begin
    idle();
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_same_reg();
    test_fixed_prio();
    test_reg_zero();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
